// File: rtl/gates_selftest.sv
// Self-test sequencer for the MUX-based gate block. It sweeps {a,b} through 00..11,
// waits for the outputs to settle, checks AND/OR/NOT and records any mismatches.
module gates_selftest #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned LOOPS         = 1,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic             and_op,
   input  logic             or_op,
   input  logic             not_op,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

   localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);
   localparam logic [7:0]       LOOPS_LIM   = 8'(LOOPS);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

   state_t     state, state_next;
   logic [1:0] idx;
   logic [7:0] settle_cnt;
   logic [7:0] loop_cnt;
   logic [7:0] loop_inc;
   logic       accept;
   logic       last_check;
   logic       mismatch;
   logic       busy_next, done_next, pass_next;

   assign accept     = start && (state == IDLE || state == DONE);
   assign loop_inc   = loop_cnt + 8'd1;
   assign last_check = (idx == 2'd3) && (loop_inc >= LOOPS_LIM);
   // Several wrong outputs in one sample still count as a single error.
   assign mismatch   = (and_op != (a & b)) || (or_op != (a | b)) || (not_op != ~a);

   // NOTE: reset is synchronous, so it is only sampled inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DRIVE;
         DRIVE:   state_next = SETTLE;
         SETTLE:  if (settle_cnt <= 8'd1) state_next = CHECK;
         CHECK:   state_next = last_check ? DONE : DRIVE;
         DONE:    if (start) state_next = DRIVE;
         default: state_next = IDLE;
      endcase
   end

   // Status flags are registered from the current state, so they lag it by one cycle.
   always_comb begin
      busy_next = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
      done_next = (state == DONE);
      pass_next = (state == DONE) && (err_count == '0);
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
         idx        <= '0;
         settle_cnt <= '0;
         loop_cnt   <= '0;
      end else begin
         busy <= busy_next;
         done <= done_next;
         pass <= pass_next;
         if (accept) begin
            err_count <= '0;
            fail_vec  <= '0;
            idx       <= '0;
            loop_cnt  <= '0;
         end else begin
            case (state)
               DRIVE: begin
                  a          <= idx[1];
                  b          <= idx[0];
                  settle_cnt <= SETTLE_INIT;
               end
               SETTLE: settle_cnt <= settle_cnt - 8'd1;
               CHECK: begin
                  if (mismatch) begin
                     if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
                     fail_vec[idx] <= 1'b1;
                  end
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) loop_cnt <= loop_inc;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/gates_selftest.md
Name: gates_selftest

Overview:
- Sequential stimulus generator and response checker for the 2-input MUX-based gate block (outputs and_op, or_op, not_op).
- Drives a/b through all four input combinations, waits a settle interval, then samples the gate outputs and compares them against expected values.
- Counts and records mismatches and reports pass/fail.
- Instantiated beside the gate block for on-chip or FPGA self-test, replacing the manual bench sweep.

Parameters:
- SETTLE_CYCLES, 2, cycles waited after driving a/b before sampling outputs; legal range 1..255.
- LOOPS, 1, number of full 4-pattern sweeps per run; legal range 1..255.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- a  output  1  stimulus to gate block, input a.
- b  output  1  stimulus to gate block, input b.
- and_op  input  1  gate block AND result.
- or_op  input  1  gate block OR result.
- not_op  input  1  gate block NOT result (NOT of a).
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  high when done=1 and err_count=0.
- err_count  output  ERR_W  number of mismatching samples; saturates at all-ones.
- fail_vec  output  4  bit i set if pattern i ({a,b}=i) failed in any loop.

Behaviour:
- Reset: rst_n=0 at a clock edge forces state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, and clears internal pattern index, settle counter and loop counter. Reset asserted mid-run aborts the run immediately with no partial result kept.
- Pattern order: idx 0..3, a=idx[1], b=idx[0]. The sequence is 00, 01, 10, 11.
- Expected values: exp_and=a&b, exp_or=a|b, exp_not=~a, all computed from the registered a/b currently driven.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: start=1 goes to DRIVE and clears err_count, fail_vec, idx and loop counter; busy=1 from the next cycle.
- DRIVE (1 cycle): a/b are registered from idx and the settle counter is loaded with SETTLE_CYCLES; goes to SETTLE.
- SETTLE: the counter decrements each cycle; when it reaches 1, goes to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle): samples and_op, or_op and not_op.
  - Any mismatch increments err_count by 1, saturating, and sets fail_vec[idx].
  - If idx<3: idx+1, go to DRIVE.
  - If idx=3: idx wraps to 0 and the loop counter increments. If the loop counter is now < LOOPS, go to DRIVE; otherwise go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). a/b hold their last value (1,1).
  - start=1 in DONE begins a new run exactly as from IDLE, and done/pass drop the next cycle.
- Latency: per pattern, 2+SETTLE_CYCLES cycles. With start accepted at edge k, done rises at edge k+1+4*LOOPS*(2+SETTLE_CYCLES).
- start while busy=1 is ignored with no effect. start held high continuously restarts a new run immediately after each DONE cycle.
- Multiple mismatching outputs in one CHECK count as a single error.
- a/b change only in DRIVE, so they are glitch-free and constant throughout SETTLE and CHECK.
- busy and done are never high simultaneously.

Test Plan:
- Correct gate block connected, SETTLE_CYCLES=2, LOOPS=1, pulse start -> a/b sequence 00,01,10,11 with each value held 4 cycles; done and pass rise 17 cycles after the start edge; err_count=0; fail_vec=0000.
- and_op stuck-at-0, LOOPS=1 -> err_count=1, fail_vec=1000, pass=0, done=1.
- not_op inverted (driven as a instead of ~a), LOOPS=3 -> err_count=12, fail_vec=1111, pass=0.
- With ERR_W=2, not_op inverted and LOOPS=2 -> err_count saturates at 3 (not 8); fail_vec=1111.
- rst_n=0 for one cycle during SETTLE of pattern 10 -> next cycle all outputs are zero and state=IDLE; a later start runs a full clean sweep ending in pass=1.
- start pulsed while busy -> no change in the sequence; done arrives at the original cycle. start in DONE -> done=0 next cycle, err_count=0, and a new sweep begins.
